pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage 16-bit pipeline. It generates the write-enable and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use hazards, taken-branch flushes, memory-busy freezes and the HLT drain sequence. It also keeps a saturating stall-cycle counter and a memory-timeout error flag.

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard inputs from the pipeline and the
// per-stage enable/flush controls returned to it.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       id_rs;
  logic [3:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic             id_halt;
  logic             ex_memread;
  logic [3:0]       ex_rd;
  logic             mem_busy;
  logic             pc_wen;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_ex_wen;
  logic             id_ex_flush;
  logic             ex_mem_wen;
  logic             mem_wb_wen;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies hazard info, consumes controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken, id_halt,
           ex_memread, ex_rd, mem_busy,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           mem_wb_wen, halted, mem_err, stall_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken, id_halt,
           ex_memread, ex_rd, mem_busy,
    output pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           mem_wb_wen, halted, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// squash, memory-busy freeze, HLT drain, stall counter and memory timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned BW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic freeze, lu, stall_evt;
  logic pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen, mem_wb_wen;

  assign freeze = bus.mem_busy && (state_q != StHalted);
  assign lu = bus.ex_memread && (bus.ex_rd != 4'd0) &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
  // Load-use only stalls in RUN; ID contents are don't-care while draining.
  assign stall_evt = (state_q != StHalted) && (freeze || ((state_q == StRun) && lu));

  // Next-state and stage controls, priority HALTED > freeze > DRAIN > lu > branch.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_wen      = 1'b1;
    if_id_wen   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_wen   = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_wen  = 1'b1;
    mem_wb_wen  = 1'b1;
    if (state_q == StHalted || freeze) begin
      pc_wen     = 1'b0;
      if_id_wen  = 1'b0;
      id_ex_wen  = 1'b0;
      ex_mem_wen = 1'b0;
      mem_wb_wen = 1'b0;
    end else begin
      unique case (state_q)
        StDrain: begin
          pc_wen      = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) state_d = StHalted;
        end
        StRun: begin
          if (lu) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_flush = 1'b1;
          end else if (bus.id_halt) begin
            // HLT advances into EX normally; the drain starts next cycle.
            state_d     = StDrain;
            drain_cnt_d = '0;
          end else if (bus.id_branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Counter and sticky-flag next-state.
  always_comb begin
    busy_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    mem_err_d   = mem_err_q;
    if (bus.mem_busy) begin
      busy_cnt_d = (busy_cnt_q == BW'(MEM_TIMEOUT)) ? busy_cnt_q : busy_cnt_q + 1'b1;
      if (busy_cnt_q == BW'(MEM_TIMEOUT - 1)) mem_err_d = 1'b1;
    end
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.pc_wen      = pc_wen;
  assign bus.if_id_wen   = if_id_wen;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_wen   = id_ex_wen;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_wen  = ex_mem_wen;
  assign bus.mem_wb_wen  = mem_wb_wen;
  assign bus.halted      = (state_q == StHalted);
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule
